seg7_scan_driver: RTL and testbench
===================================

// Module: seg7_scan_driver
// PURPOSE
//   Time-multiplexed N-digit BCD-to-7-segment display driver; successor to the per-digit static decoder.
//   Latches a packed BCD word into a shadow register, scans one digit per SCAN_DIV clocks,
//   with optional leading-zero blanking and blink. Sits between the timer counters and the panel pins.
// PARAMETERS
//   NUM_DIGITS  3     digits scanned; digit 0 = least significant (sec ones); >=1
//   SCAN_DIV    1000  clocks each digit stays selected; >=1
//   BLINK_DIV   50    complete frames per blink half-period; >=1
//   SEG_ACT_LOW 0     1: segs/dp_out driven active-low (common anode)
//   AN_ACT_LOW  0     1: an driven active-low
// PORTS
//   clk         in   1             system clock, rising edge
//   rst_n       in   1             async active-low reset
//   load        in   1             1-cycle strobe: shadow <= digits, shadow_dp <= dp
//   digits      in   4*NUM_DIGITS  packed BCD; digit k = digits[4k+3:4k]
//   dp          in   NUM_DIGITS    decimal point per digit
//   lzb_en      in   1             leading-zero blanking enable
//   blink_en    in   1             blink whole display
//   segs        out  7             {g,f,e,d,c,b,a} of selected digit
//   dp_out      out  1             decimal point of selected digit
//   an          out  NUM_DIGITS    one-hot digit select (or all inactive)
//   frame_tick  out  1             1-cycle pulse when scan index wraps to 0
// BEHAVIOUR
//   - Reset (async on rst_n=0): prescaler=0, idx=0, shadow=0, shadow_dp=0, blink phase=ON,
//     blink frame count=0; an all inactive, segs/dp_out unlit, frame_tick=0. Release is synchronous-safe.
//   - Outputs registered: an/segs/dp_out reflect idx, shadow, lzb_en, blink state of previous cycle (latency 1).
//   - Load: shadow updates on the load edge; visible on outputs the following cycle. load held high reloads each cycle.
//   - Scan: prescaler counts 0..SCAN_DIV-1; at SCAN_DIV-1 it wraps and idx <= (idx==NUM_DIGITS-1)?0:idx+1.
//     Each digit is selected for exactly SCAN_DIV cycles. frame_tick=1 for the cycle idx becomes 0.
//     NUM_DIGITS=1: idx fixed 0, frame_tick pulses every SCAN_DIV cycles. SCAN_DIV=1: idx advances every cycle.
//   - Decode (active-high before polarity): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F; 10..15 -> dash 40.
//   - LZB: when lzb_en=1, digit k (k>=1) is blank (segs=00, dp unlit) if it and all digits above it are 0.
//     Digit 0 never blanked. Nibble >9 counts as non-zero. dp of a non-blank digit follows shadow_dp.
//   - Blink: when blink_en=1, phase toggles after BLINK_DIV frame_ticks; phase OFF -> an all inactive.
//     blink_en=0 -> phase forced ON and frame count cleared that cycle; display resumes next cycle.
//   - Simultaneous load and idx advance: both take effect; next output uses new idx and new shadow.
//   - Polarity params invert only the pin drive; reset values are "inactive/unlit" in the chosen polarity.
//   - Reset mid-scan: immediate return to reset state; no partial frame_tick.
// STRUCTURE
//   - Package seg7_pkg: SEG_0..SEG_9, SEG_BLANK=7'h00, SEG_DASH=7'h40, function bcd_to_seg(nibble).
//   - Sub-module seg7_decode (combinational nibble -> 7 segs), single instance on muxed digit.
//   - Top: prescaler, idx counter, blink counter/phase, shadow regs, LZB mask, output regs.
// TESTING (NUM_DIGITS=3, SCAN_DIV=4, BLINK_DIV=2, polarities 0)
//   - Reset then idle: an cycles 001->010->100->001, 4 clocks each; all segs=3F; frame_tick every 12 clocks.
//   - load digits=12'h905, dp=3'b010: digit0 segs=6D, digit1 segs=3F dp_out=1, digit2 segs=6F; visible 1 cycle after load.
//   - lzb_en=1, digits=12'h007: digit0=07, digits 1,2 segs=00; digits=12'h0A0: digit1=40, digit2=00, digit0=3F.
//   - blink_en=1: an active 2 frames (24 clk), all-inactive 2 frames, repeating; drop blink_en -> an active next cycle.
//   - load asserted on the cycle idx advances 0->1: digit1 shown next cycle with new value; no glitch value.
//   - rst_n low mid-digit 1 (async, between edges): an/segs go inactive immediately; restart at idx 0 after release.

Source files
------------

// File: rtl/seg7_pkg.sv
// seg7_pkg: segment codes, blink phase type and the nibble-to-segment helper for the scan driver.
package seg7_pkg;
  localparam logic [6:0] SEG_0     = 7'h3F;
  localparam logic [6:0] SEG_1     = 7'h06;
  localparam logic [6:0] SEG_2     = 7'h5B;
  localparam logic [6:0] SEG_3     = 7'h4F;
  localparam logic [6:0] SEG_4     = 7'h66;
  localparam logic [6:0] SEG_5     = 7'h6D;
  localparam logic [6:0] SEG_6     = 7'h7D;
  localparam logic [6:0] SEG_7     = 7'h07;
  localparam logic [6:0] SEG_8     = 7'h7F;
  localparam logic [6:0] SEG_9     = 7'h6F;
  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_DASH  = 7'h40;
  typedef enum logic {PH_OFF, PH_ON} blink_ph_e;
  function automatic logic [6:0] bcd_to_seg(input logic [3:0] n);
    case (n)
      4'd0: return SEG_0;
      4'd1: return SEG_1;
      4'd2: return SEG_2;
      4'd3: return SEG_3;
      4'd4: return SEG_4;
      4'd5: return SEG_5;
      4'd6: return SEG_6;
      4'd7: return SEG_7;
      4'd8: return SEG_8;
      4'd9: return SEG_9;
      default: return SEG_DASH;
    endcase
  endfunction
endpackage

// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_if: timer-side inputs and panel-side outputs of the scan driver.
//   master: load, digits, dp, lzb_en, blink_en out; segs, dp_out, an, frame_tick in
//   slave : the driver's view (directions reversed)
interface seg7_scan_if #(parameter int NUM_DIGITS = 3);
  logic                    load;
  logic [4*NUM_DIGITS-1:0] digits;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    lzb_en;
  logic                    blink_en;
  logic [6:0]              segs;
  logic                    dp_out;
  logic [NUM_DIGITS-1:0]   an;
  logic                    frame_tick;
  modport master (output load, digits, dp, lzb_en, blink_en, input segs, dp_out, an, frame_tick);
  modport slave  (input load, digits, dp, lzb_en, blink_en, output segs, dp_out, an, frame_tick);
endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: combinational BCD nibble to active-high {g..a}; nibbles above 9 show a dash.
//   nibble_i in 4, seg_o out 7
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);
  assign seg_o = bcd_to_seg(nibble_i);
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed N-digit BCD to 7-segment driver with blanking and blink.
//   clk, rst_n (async active-low); bus: seg7_scan_if.slave, NUM_DIGITS must match the interface.
//   All panel outputs are registered; polarity params only invert the pin drive.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS  = 3,
  parameter int SCAN_DIV    = 1000,
  parameter int BLINK_DIV   = 50,
  parameter bit SEG_ACT_LOW = 1'b0,
  parameter bit AN_ACT_LOW  = 1'b0
) (
  input logic        clk,
  input logic        rst_n,
  seg7_scan_if.slave bus
);
  localparam int PW = SCAN_DIV   > 1 ? $clog2(SCAN_DIV)   : 1;
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int BW = BLINK_DIV  > 1 ? $clog2(BLINK_DIV)  : 1;
  logic [PW-1:0]           pre_q, pre_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [BW-1:0]           bcnt_q, bcnt_d;
  blink_ph_e               ph_q, ph_d;
  logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
  logic [NUM_DIGITS-1:0]   sdp_q, sdp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [6:0]              segs_q, segs_d;
  logic                    dp_q, dp_d;
  logic                    tick_q, tick_d;
  logic                    wrap, last, show, blink_wrap;
  logic [NUM_DIGITS-1:0]   blank;
  logic [3:0]              nib;
  logic [6:0]              seg_raw;
  seg7_decode u_dec (.nibble_i(nib), .seg_o(seg_raw));
  // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    logic z;
    blank = '0;
    z = 1'b1;
    for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
      z = z && (shadow_q[4*k +: 4] == 4'd0);
      blank[k] = bus.lzb_en && (k != 0) && z;
    end
  end
  always_comb begin
    wrap       = pre_q == PW'(SCAN_DIV - 1);
    last       = idx_q == IW'(NUM_DIGITS - 1);
    pre_d      = wrap ? '0 : pre_q + 1'b1;
    idx_d      = !wrap ? idx_q : last ? '0 : idx_q + 1'b1;
    tick_d     = wrap && last;
    shadow_d   = bus.load ? bus.digits : shadow_q;
    sdp_d      = bus.load ? bus.dp : sdp_q;
    blink_wrap = tick_q && (bcnt_q == BW'(BLINK_DIV - 1));
    bcnt_d     = !bus.blink_en ? '0 : !tick_q ? bcnt_q : blink_wrap ? '0 : bcnt_q + 1'b1;
    ph_d       = !bus.blink_en ? PH_ON : blink_wrap ? (ph_q == PH_ON ? PH_OFF : PH_ON) : ph_q;
    // Dropping blink_en lights the display on the very next output update.
    show       = !bus.blink_en || (ph_q == PH_ON);
    nib        = shadow_q[4*idx_q +: 4];
    an_d       = show ? NUM_DIGITS'(1) << idx_q : '0;
    segs_d     = blank[idx_q] ? SEG_BLANK : seg_raw;
    dp_d       = !blank[idx_q] && sdp_q[idx_q];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pre_q    <= '0;
      idx_q    <= '0;
      bcnt_q   <= '0;
      ph_q     <= PH_ON;
      shadow_q <= '0;
      sdp_q    <= '0;
      an_q     <= '0;
      segs_q   <= SEG_BLANK;
      dp_q     <= 1'b0;
      tick_q   <= 1'b0;
    end else begin
      pre_q    <= pre_d;
      idx_q    <= idx_d;
      bcnt_q   <= bcnt_d;
      ph_q     <= ph_d;
      shadow_q <= shadow_d;
      sdp_q    <= sdp_d;
      an_q     <= an_d;
      segs_q   <= segs_d;
      dp_q     <= dp_d;
      tick_q   <= tick_d;
    end
  end
  assign bus.an         = AN_ACT_LOW  ? ~an_q   : an_q;
  assign bus.segs       = SEG_ACT_LOW ? ~segs_q : segs_q;
  assign bus.dp_out     = SEG_ACT_LOW ? ~dp_q   : dp_q;
  assign bus.frame_tick = tick_q;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: randomized scoreboard bench with a cycle-count reference model of the scan driver.
module tb_seg7_scan_driver;
  localparam int N = 3, SD = 4, BD = 2;
  typedef struct packed {
    logic [N-1:0] an;
    logic [6:0]   segs;
    logic         dp;
    logic         tick;
  } obs_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  seg7_scan_if #(.NUM_DIGITS(N)) bus();
  seg7_scan_driver #(
    .NUM_DIGITS(N), .SCAN_DIV(SD), .BLINK_DIV(BD), .SEG_ACT_LOW(1'b0), .AN_ACT_LOW(1'b0)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  obs_t exp_q[$];
  int vectors = 0, miscompares = 0;
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int c, nticks, d;
  logic prev_tick, on, allz, blank;
  logic [3:0] sh [N];
  logic [N-1:0] shdp;
  obs_t e;
  function automatic obs_t observed();
    return {bus.an, bus.segs, bus.dp_out, bus.frame_tick};
  endfunction
  task automatic check(input string name, input obs_t got, input obs_t want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s t=%0t got an=%b segs=%h dp=%b tick=%b, expected an=%b segs=%h dp=%b tick=%b",
               name, $time, got.an, got.segs, got.dp, got.tick, want.an, want.segs, want.dp, want.tick);
    end
  endtask
  // Reference: cycle c since reset selects digit (c/SD)%N; a frame ends every SD*N cycles;
  // blink phase is ON while (ticks seen with blink enabled)/BD is even.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c = 0;
      nticks = 0;
      prev_tick = 1'b0;
      for (int k = 0; k < N; k++) sh[k] = 4'd0;
      shdp = '0;
    end else begin
      d = (c / SD) % N;
      on = !bus.blink_en || ((nticks / BD) % 2 == 0);
      allz = 1'b1;
      for (int j = d; j < N; j++) if (sh[j] != 4'd0) allz = 1'b0;
      blank = bus.lzb_en && (d >= 1) && allz;
      e.an = on ? N'(1) << d : '0;
      e.segs = blank ? 7'h00 : (sh[d] > 4'd9 ? 7'h40 : seg_tab[sh[d]]);
      e.dp = !blank && shdp[d];
      e.tick = ((c + 1) % (SD * N)) == 0;
      exp_q.push_back(e);
      if (!bus.blink_en) nticks = 0;
      else if (prev_tick) nticks++;
      prev_tick = e.tick;
      if (bus.load) begin
        for (int k = 0; k < N; k++) sh[k] = bus.digits[4*k +: 4];
        shdp = bus.dp;
      end
      c++;
    end
  end
  always @(negedge clk) begin
    if (rst_n && exp_q.size() > 0) check("scan", observed(), exp_q.pop_front());
  end
  function automatic logic [4*N-1:0] rnd_digits();
    logic [4*N-1:0] v;
    v = '0;
    for (int k = 0; k < N; k++) v[4*k +: 4] = $urandom_range(0, 1) == 0 ? 4'd0 : 4'($urandom_range(0, 15));
    return v;
  endfunction
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic do_load(input logic [4*N-1:0] dg, input logic [N-1:0] p);
    @(negedge clk);
    bus.digits = dg;
    bus.dp = p;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  task automatic rand_run(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.load = $urandom_range(0, 7) == 0;
      bus.digits = rnd_digits();
      bus.dp = N'($urandom);
      if ($urandom_range(0, 40) == 0) bus.lzb_en = ~bus.lzb_en;
      if ($urandom_range(0, 150) == 0) bus.blink_en = ~bus.blink_en;
    end
    @(negedge clk);
    bus.load = 1'b0;
  endtask
  initial begin
    bus.load = 1'b0;
    bus.digits = '0;
    bus.dp = '0;
    bus.lzb_en = 1'b0;
    bus.blink_en = 1'b0;
    #12 check("reset", observed(), '0);
    @(negedge clk) rst_n = 1'b1;
    cyc(30);
    do_load(12'h905, 3'b010);
    cyc(30);
    bus.lzb_en = 1'b1;
    do_load(12'h007, 3'b000);
    cyc(14);
    do_load(12'h0A0, 3'b111);
    cyc(14);
    bus.lzb_en = 1'b0;
    cyc(14);
    bus.blink_en = 1'b1;
    cyc(110);
    bus.blink_en = 1'b0;
    cyc(10);
    bus.load = 1'b1;
    repeat (20) begin
      bus.digits = rnd_digits();
      bus.dp = N'($urandom);
      @(negedge clk);
    end
    bus.load = 1'b0;
    rand_run(800);
    bus.blink_en = 1'b0;
    cyc(30);
    repeat (SD * N + 1) begin
      @(posedge clk);
      if (bus.an === 3'b010) break;
    end
    #2 rst_n = 1'b0;
    exp_q.delete();
    #1 check("async_rst", observed(), '0);
    @(negedge clk);
    check("rst_hold", observed(), '0);
    rst_n = 1'b1;
    rand_run(200);
    cyc(5);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
